taylor_mac_sequencer: RTL and testbench
=======================================

// Module: taylor_mac_sequencer
// PURPOSE
//  Sequences one Taylor-series evaluation on the mac engine.
//  Holds a 2**ADDR_LINES-entry IEEE-754 fp32 coefficient table, written by config port.
//  On start: streams x (sample) beats and coefficient beats into mac, highest order first, honouring mac back-pressure.
//  Then waits for the mac pipeline to drain and returns the result with a done pulse.
// PARAMETERS
//  DATA_WIDTH  32    fp32 word width of samples, coefficients and result
//  ADDR_LINES  5     coefficient table address width; max order = 2**ADDR_LINES-1
//  DRAIN_CYC   4     consecutive cycles with both mac FIFOs empty before result capture
//  TIMEOUT     4096  max cycles in DRAIN before aborting with err_o
// PORTS
//  clk_i              in   1           system clock, rising edge
//  rstn_i             in   1           asynchronous active-low reset
//  start_i            in   1           begin evaluation; sampled only in IDLE
//  x_i                in   DATA_WIDTH  sample, latched with start_i
//  len_i              in   ADDR_LINES  series order N, latched with start_i
//  cfg_we_i           in   1           coefficient table write strobe
//  cfg_addr_i         in   ADDR_LINES  table index k (coefficient of x^k)
//  cfg_data_i         in   DATA_WIDTH  coefficient value
//  busy_o             out  1           high from accepted start to done_o
//  done_o             out  1           one-cycle pulse, y_o/err_o valid
//  err_o              out  1           drain timeout flag, valid with done_o
//  y_o                out  DATA_WIDTH  captured result, held until next done_o
//  mac_signal_o       out  DATA_WIDTH  to mac signal_fifo
//  mac_coeff_o        out  DATA_WIDTH  to mac coeff_fifo
//  mac_taylor_len_o   out  ADDR_LINES  to mac taylor_length (latched N)
//  mac_wr_en_sig_o    out  1           signal beat strobe
//  mac_wr_en_coeff_o  out  1           coefficient beat strobe
//  mac_last_sig_o     out  1           end-of-signal-stream pulse
//  mac_last_coeff_o   out  1           end-of-coefficient-stream pulse
//  mac_idle_sig_i     in   1           mac signal input ready
//  mac_idle_coeff_i   in   1           mac coefficient input ready
//  mac_full_mul_i     in   1           mac multiplier FIFO full
//  mac_empty_mul_i    in   1           mac multiplier FIFO empty
//  mac_empty_add_i    in   1           mac adder FIFO empty
//  mac_result_i       in   DATA_WIDTH  mac result
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; counters 0.
//  Reset mid-run aborts immediately, with no done_o.
//  Coefficient table is not reset.
//  cfg_we_i writes in 1 cycle when not busy_o; writes while busy_o are ignored.
//  FSM states: IDLE, ISSUE, LAST, DRAIN, DONE.
//  IDLE: start_i=1 -> latch x_i, len_i; set busy_o; coefficient index k=N; signal count s=N; go to ISSUE next cycle.
//  ISSUE: a beat is legal when mac_idle_sig_i & mac_idle_coeff_i & !mac_full_mul_i.
//   - Coefficient strobe: on each legal cycle, wr_en_coeff=1 with coeff=table[k], then k decrements.
//   - Signal strobe: on the same cycle, wr_en_sig=1 with signal=x, only while s>0; s decrements.
//   - Illegal cycle: both strobes 0, and data holds its last value.
//   - After the c[0] beat (N+1 coefficient beats, N signal beats total) -> go to LAST.
//  LAST: one cycle; mac_last_sig_o=1 and mac_last_coeff_o=1 (single pulse each); go to DRAIN.
//  DRAIN: a counter counts consecutive cycles with mac_empty_mul_i & mac_empty_add_i.
//   - Any non-empty cycle resets the counter.
//   - Counter reaches DRAIN_CYC -> y_o <= mac_result_i; go to DONE.
//   - TIMEOUT cycles in DRAIN -> err_o=1; y_o is unchanged; go to DONE.
//  DONE: done_o=1 for one cycle; busy_o drops in the same cycle; go to IDLE.
//   - err_o clears at the next accepted start_i.
//  N=0: one coefficient beat (c[0]) and zero signal beats, then LAST as normal.
//  start_i while busy_o is ignored.
//  start_i in the DONE cycle is ignored; it is accepted one cycle later in IDLE.
//  Minimum latency, no stalls: start -> done_o = N+1 issue + 1 last + DRAIN_CYC + 1 cycles (+ mac drain).
// TESTING
//  1. Table loaded with tanh coeffs c[0..30]; start x=0x3E308D3D, N=30, mac always ready
//     -> 31 coeff beats in order c30..c0, 30 signal beats all 0x3E308D3D, one last pulse each,
//     done_o once, y_o = mac result.
//  2. N=0, c[0]=0x3F800000 -> exactly 1 coeff beat, 0 signal beats, y_o=0x3F800000.
//  3. Hold mac_full_mul_i=1 for 5 cycles mid-ISSUE
//     -> no strobes during the stall, no beat lost or duplicated, beat counts unchanged.
//  4. Tie mac_empty_add_i=0 -> done_o with err_o=1 after TIMEOUT DRAIN cycles; y_o holds its previous value.
//  5. cfg write to k=3 and a second start_i while busy
//     -> table[3] unchanged, run unaffected, only one done_o.
//  6. Deassert rstn_i during ISSUE
//     -> outputs 0 asynchronously, no done_o, next start runs cleanly with table intact.

Source files
------------

// File: rtl/taylor_mac_sequencer_if.sv
// taylor_mac_sequencer_if
//   Groups the sequencer <-> mac engine bus.
//   The sequencer drives the operand streams and their strobes/last pulses.
//   The mac engine returns its readiness, its FIFO status and its result.
//   The signal names keep the sequencer's point of view: *_o is driven by the
//   sequencer and *_i is driven by the mac engine.
// Ports (interface signals)
//   mac_signal_o       DATA_WIDTH  sample beat data      (sequencer -> mac)
//   mac_coeff_o        DATA_WIDTH  coefficient beat data (sequencer -> mac)
//   mac_taylor_len_o   ADDR_LINES  latched series order N
//   mac_wr_en_sig_o    1           sample beat strobe
//   mac_wr_en_coeff_o  1           coefficient beat strobe
//   mac_last_sig_o     1           end of sample stream pulse
//   mac_last_coeff_o   1           end of coefficient stream pulse
//   mac_idle_sig_i     1           mac ready for a sample beat
//   mac_idle_coeff_i   1           mac ready for a coefficient beat
//   mac_full_mul_i     1           mac multiplier FIFO full
//   mac_empty_mul_i    1           mac multiplier FIFO empty
//   mac_empty_add_i    1           mac adder FIFO empty
//   mac_result_i       DATA_WIDTH  mac accumulated result
// Modports
//   master  the sequencer side
//   slave   the mac engine side
interface taylor_mac_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_LINES = 5
) ();

  logic [DATA_WIDTH-1:0] mac_signal_o;
  logic [DATA_WIDTH-1:0] mac_coeff_o;
  logic [ADDR_LINES-1:0] mac_taylor_len_o;
  logic                  mac_wr_en_sig_o;
  logic                  mac_wr_en_coeff_o;
  logic                  mac_last_sig_o;
  logic                  mac_last_coeff_o;
  logic                  mac_idle_sig_i;
  logic                  mac_idle_coeff_i;
  logic                  mac_full_mul_i;
  logic                  mac_empty_mul_i;
  logic                  mac_empty_add_i;
  logic [DATA_WIDTH-1:0] mac_result_i;

  modport master (
    output mac_signal_o,
    output mac_coeff_o,
    output mac_taylor_len_o,
    output mac_wr_en_sig_o,
    output mac_wr_en_coeff_o,
    output mac_last_sig_o,
    output mac_last_coeff_o,
    input  mac_idle_sig_i,
    input  mac_idle_coeff_i,
    input  mac_full_mul_i,
    input  mac_empty_mul_i,
    input  mac_empty_add_i,
    input  mac_result_i
  );

  modport slave (
    input  mac_signal_o,
    input  mac_coeff_o,
    input  mac_taylor_len_o,
    input  mac_wr_en_sig_o,
    input  mac_wr_en_coeff_o,
    input  mac_last_sig_o,
    input  mac_last_coeff_o,
    output mac_idle_sig_i,
    output mac_idle_coeff_i,
    output mac_full_mul_i,
    output mac_empty_mul_i,
    output mac_empty_add_i,
    output mac_result_i
  );

endinterface

// File: rtl/taylor_mac_sequencer.sv
// taylor_mac_sequencer
//   Sequences one Taylor-series evaluation on the mac engine.
//   A 2**ADDR_LINES entry fp32 coefficient table is loaded through the cfg
//   port while the sequencer is not busy.  On start the sample x and the
//   series order N are latched.  Coefficient beats c[N]..c[0] and N sample
//   beats are then issued to the mac, highest order first, only on cycles the
//   mac can accept them.  A single last pulse closes both streams, the mac
//   pipeline is allowed to drain, and the result is returned with done_o.
//   If the mac never drains, the run is aborted after TIMEOUT cycles with err_o.
// Ports
//   clk_i       system clock, rising edge
//   rstn_i      asynchronous active-low reset
//   start_i     begin an evaluation (accepted only in IDLE)
//   x_i         sample, latched with an accepted start
//   len_i       series order N, latched with an accepted start
//   cfg_we_i    coefficient table write strobe (ignored while busy)
//   cfg_addr_i  coefficient index k (coefficient of x^k)
//   cfg_data_i  coefficient value
//   busy_o      high from accepted start until the done cycle
//   done_o      one-cycle completion pulse; y_o/err_o valid
//   err_o       drain timeout flag
//   y_o         captured result, held until the next done
//   mac         sequencer side of the mac bus
module taylor_mac_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_LINES = 5,
  parameter int DRAIN_CYC  = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      start_i,
  input  logic [DATA_WIDTH-1:0]     x_i,
  input  logic [ADDR_LINES-1:0]     len_i,
  input  logic                      cfg_we_i,
  input  logic [ADDR_LINES-1:0]     cfg_addr_i,
  input  logic [DATA_WIDTH-1:0]     cfg_data_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic [DATA_WIDTH-1:0]     y_o,
  taylor_mac_sequencer_if.master    mac
);

  localparam int DEPTH = 2 ** ADDR_LINES;
  localparam int DCW   = $clog2(DRAIN_CYC + 1);
  localparam int TCW   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    LAST,
    DRAIN,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] x_q, x_d;
  logic [ADDR_LINES-1:0] len_q, len_d;
  logic [ADDR_LINES-1:0] k_q, k_d;
  logic [ADDR_LINES-1:0] s_q, s_d;
  logic [DCW-1:0]        drain_q, drain_d;
  logic [TCW-1:0]        tmo_q, tmo_d;
  logic [DATA_WIDTH-1:0] y_q, y_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] sig_hold_q, sig_hold_d;
  logic [DATA_WIDTH-1:0] coeff_hold_q, coeff_hold_d;

  logic [DATA_WIDTH-1:0] coeff_mem [DEPTH];
  logic [DATA_WIDTH-1:0] coeff_rd;
  logic                  busy;
  logic                  beat_legal;
  logic                  drain_empty;
  logic                  coeff_beat;
  logic                  sig_beat;

  assign busy        = (state_q == ISSUE) || (state_q == LAST) || (state_q == DRAIN);
  assign beat_legal  = mac.mac_idle_sig_i & mac.mac_idle_coeff_i & ~mac.mac_full_mul_i;
  assign drain_empty = mac.mac_empty_mul_i & mac.mac_empty_add_i;
  assign coeff_rd    = coeff_mem[k_q];

  // Coefficient table: deliberately has no reset so a loaded table survives
  // a reset of the sequencer.  Writes during a run are dropped so the table
  // cannot change underneath the coefficient stream.
  always_ff @(posedge clk_i) begin
    if (cfg_we_i && !busy) begin
      coeff_mem[cfg_addr_i] <= cfg_data_i;
    end
  end

  // State and datapath registers.  Everything the outside world sees comes
  // from these, so an asserted reset forces all outputs low immediately.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= IDLE;
      x_q          <= '0;
      len_q        <= '0;
      k_q          <= '0;
      s_q          <= '0;
      drain_q      <= '0;
      tmo_q        <= '0;
      y_q          <= '0;
      err_q        <= 1'b0;
      sig_hold_q   <= '0;
      coeff_hold_q <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      len_q        <= len_d;
      k_q          <= k_d;
      s_q          <= s_d;
      drain_q      <= drain_d;
      tmo_q        <= tmo_d;
      y_q          <= y_d;
      err_q        <= err_d;
      sig_hold_q   <= sig_hold_d;
      coeff_hold_q <= coeff_hold_d;
    end
  end

  // Next-state logic.  k walks the table from N down to 0 and one coefficient
  // beat is issued per legal cycle; s counts the N sample beats that ride
  // along with the first N coefficient beats, so c[0] goes out alone.  The
  // hold registers remember the last data issued so the data buses stay
  // steady on stalled cycles.  In DRAIN a capture on the final cycle of the
  // timeout window takes priority over the timeout.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    len_d        = len_q;
    k_d          = k_q;
    s_d          = s_q;
    drain_d      = drain_q;
    tmo_d        = tmo_q;
    y_d          = y_q;
    err_d        = err_q;
    sig_hold_d   = sig_hold_q;
    coeff_hold_d = coeff_hold_q;
    coeff_beat   = 1'b0;
    sig_beat     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          x_d     = x_i;
          len_d   = len_i;
          k_d     = len_i;
          s_d     = len_i;
          err_d   = 1'b0;
          drain_d = '0;
          tmo_d   = '0;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        if (beat_legal) begin
          coeff_beat   = 1'b1;
          coeff_hold_d = coeff_rd;
          if (s_q != '0) begin
            sig_beat   = 1'b1;
            sig_hold_d = x_q;
            s_d        = s_q - 1'b1;
          end
          if (k_q == '0) begin
            state_d = LAST;
          end else begin
            k_d = k_q - 1'b1;
          end
        end
      end

      LAST: begin
        drain_d = '0;
        tmo_d   = '0;
        state_d = DRAIN;
      end

      DRAIN: begin
        tmo_d = tmo_q + 1'b1;
        if (drain_empty) begin
          if (drain_q == DCW'(DRAIN_CYC - 1)) begin
            y_d     = mac.mac_result_i;
            state_d = DONE;
          end else begin
            drain_d = drain_q + 1'b1;
          end
        end else begin
          drain_d = '0;
        end
        if ((state_d != DONE) && (tmo_q == TCW'(TIMEOUT - 1))) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Strobes are combinational on the legal-beat condition so a beat is only
  // ever presented on a cycle the mac has declared it can take it.
  assign mac.mac_wr_en_coeff_o = coeff_beat;
  assign mac.mac_wr_en_sig_o   = sig_beat;
  assign mac.mac_coeff_o       = coeff_beat ? coeff_rd : coeff_hold_q;
  assign mac.mac_signal_o      = sig_beat ? x_q : sig_hold_q;
  assign mac.mac_taylor_len_o  = len_q;
  assign mac.mac_last_sig_o    = (state_q == LAST);
  assign mac.mac_last_coeff_o  = (state_q == LAST);

  assign busy_o = busy;
  assign done_o = (state_q == DONE);
  assign err_o  = err_q;
  assign y_o    = y_q;

endmodule

// File: tb/tb_taylor_mac_sequencer.sv
// tb_taylor_mac_sequencer
//   Directed bench for taylor_mac_sequencer.  The bench plays the mac engine,
//   keeps its own copy of the coefficient table, and predicts from it the
//   ordered coefficient stream, the sample beats and the run latency.
module tb_taylor_mac_sequencer;

  localparam int DW        = 32;
  localparam int AL        = 5;
  localparam int DRAIN_CYC = 4;
  localparam int TIMEOUT   = 4096;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          start;
  logic [DW-1:0] x;
  logic [AL-1:0] len;
  logic          cfg_we;
  logic [AL-1:0] cfg_addr;
  logic [DW-1:0] cfg_data;
  logic          busy;
  logic          done;
  logic          err;
  logic [DW-1:0] y;

  taylor_mac_sequencer_if #(.DATA_WIDTH(DW), .ADDR_LINES(AL)) mac_bus ();

  taylor_mac_sequencer #(
    .DATA_WIDTH(DW),
    .ADDR_LINES(AL),
    .DRAIN_CYC(DRAIN_CYC),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk),
    .rstn_i(rstn),
    .start_i(start),
    .x_i(x),
    .len_i(len),
    .cfg_we_i(cfg_we),
    .cfg_addr_i(cfg_addr),
    .cfg_data_i(cfg_data),
    .busy_o(busy),
    .done_o(done),
    .err_o(err),
    .y_o(y),
    .mac(mac_bus)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Reference model state: the bench's own view of the table and the
  // streams the current run must produce.
  logic [DW-1:0] model_table [32];
  logic [DW-1:0] exp_coeff [$];
  logic [DW-1:0] exp_x;
  int            exp_len;
  int            exp_coeff_total;
  int            exp_sig_total;
  int            coeff_beats;
  int            sig_beats;
  int            last_sig_cnt;
  int            last_coeff_cnt;
  int            done_cnt;
  logic [DW-1:0] c1_seen;
  bit            chk_en;
  int            n_checks;
  int            n_errors;

  // One comparison: counts it, and reports it when actual differs.
  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Double -> fp32 bit pattern (mantissa truncated), for the coefficient table.
  function automatic logic [DW-1:0] toF32(input real r);
    logic [63:0] b;
    int          e;
    if (r == 0.0) return '0;
    b = $realtobits(r);
    e = int'(b[62:52]) - 1023 + 127;
    return {b[63], 8'(e), b[51:29]};
  endfunction

  // Maclaurin coefficients of tanh: odd powers only.
  function automatic real tanhCoef(input int k);
    case (k)
      1:  return 1.0;
      3:  return -1.0 / 3.0;
      5:  return 2.0 / 15.0;
      7:  return -17.0 / 315.0;
      9:  return 62.0 / 2835.0;
      11: return -1382.0 / 155925.0;
      13: return 21844.0 / 6081075.0;
      15: return -929569.0 / 638512875.0;
      17: return 5.90027e-4;
      19: return -2.39129e-4;
      21: return 9.69154e-5;
      23: return -3.92783e-5;
      25: return 1.59189e-5;
      27: return -6.45169e-6;
      29: return 2.61477e-6;
      default: return 0.0;
    endcase
  endfunction

  // Compare process: checks every beat, last pulse and done against the model.
  always @(negedge clk) begin
    logic legal;
    legal = mac_bus.mac_idle_sig_i & mac_bus.mac_idle_coeff_i & ~mac_bus.mac_full_mul_i;
    if (done) done_cnt++;
    if (chk_en) begin
      if (mac_bus.mac_wr_en_coeff_o) begin
        checkOutput("coeff_beat_legal", legal, 1'b1);
        checkOutput("coeff_beat_expected", exp_coeff.size() != 0, 1'b1);
        if (exp_coeff.size() != 0) begin
          checkOutput("coeff_data", mac_bus.mac_coeff_o, exp_coeff.pop_front());
        end
        checkOutput("taylor_len", mac_bus.mac_taylor_len_o, exp_len);
        if (coeff_beats == exp_coeff_total - 2) c1_seen = mac_bus.mac_coeff_o;
        coeff_beats++;
      end
      if (mac_bus.mac_wr_en_sig_o) begin
        checkOutput("sig_beat_legal", legal, 1'b1);
        checkOutput("sig_data", mac_bus.mac_signal_o, exp_x);
        sig_beats++;
      end
      if (mac_bus.mac_last_sig_o || mac_bus.mac_last_coeff_o) begin
        checkOutput("last_pair", mac_bus.mac_last_sig_o, mac_bus.mac_last_coeff_o);
        checkOutput("last_after_all_coeffs", coeff_beats, exp_coeff_total);
      end
      if (mac_bus.mac_last_sig_o) last_sig_cnt++;
      if (mac_bus.mac_last_coeff_o) last_coeff_cnt++;
      if (done) begin
        checkOutput("busy_low_at_done", busy, 1'b0);
        checkOutput("coeff_beat_count", coeff_beats, exp_coeff_total);
        checkOutput("sig_beat_count", sig_beats, exp_sig_total);
        checkOutput("last_sig_count", last_sig_cnt, 1);
        checkOutput("last_coeff_count", last_coeff_cnt, 1);
      end
    end
  end

  task automatic cfgWrite(input int addr, input logic [DW-1:0] data);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_addr = AL'(addr); cfg_data = data;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    model_table[addr] = data;
  endtask

  task automatic setMacIdle();
    mac_bus.mac_idle_sig_i   = 1'b1;
    mac_bus.mac_idle_coeff_i = 1'b1;
    mac_bus.mac_full_mul_i   = 1'b0;
    mac_bus.mac_empty_mul_i  = 1'b1;
    mac_bus.mac_empty_add_i  = 1'b1;
  endtask

  // One evaluation.  Cycle 1 is the first cycle after the start is taken.
  // stall_at/stall_len hold mac_full_mul_i, gap_at drops mac_idle_sig_i for a
  // cycle, glitch_at drops mac_empty_mul_i for a cycle, add_stuck ties
  // mac_empty_add_i low, poke issues a cfg write to k=3 and a second start
  // in cycle 3.  A zero cycle number disables that feature.
  task automatic applyStimulus(input string tag, input int n, input logic [DW-1:0] xv,
                               input logic [DW-1:0] res, input int stall_at,
                               input int stall_len, input int gap_at, input int glitch_at,
                               input bit add_stuck, input bit poke, input int exp_lat,
                               input bit exp_err, input logic [DW-1:0] exp_y);
    int cyc;
    bit got;
    exp_coeff.delete();
    for (int k = n; k >= 0; k--) exp_coeff.push_back(model_table[k]);
    exp_x = xv; exp_len = n;
    exp_coeff_total = n + 1; exp_sig_total = n;
    coeff_beats = 0; sig_beats = 0; last_sig_cnt = 0; last_coeff_cnt = 0;
    c1_seen = '0;
    mac_bus.mac_result_i = res;
    @(posedge clk); #1;
    start = 1'b1; x = xv; len = AL'(n);
    @(posedge clk); #1;
    start = 1'b0; x = 32'hA5A5_5A5A; len = 5'd17;
    cyc = 1; got = 0;
    while (!got && cyc <= 5000) begin
      mac_bus.mac_full_mul_i  = (cyc >= stall_at) && (cyc < stall_at + stall_len);
      mac_bus.mac_idle_sig_i  = (cyc != gap_at);
      mac_bus.mac_empty_mul_i = (cyc != glitch_at);
      mac_bus.mac_empty_add_i = !add_stuck;
      if (poke) begin
        start    = (cyc == 3);
        len      = 5'd5;
        cfg_we   = (cyc == 3);
        cfg_addr = 5'd3;
        cfg_data = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      if (cyc == 1) checkOutput({tag, "_busy_after_start"}, busy, 1'b1);
      if (done) got = 1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    checkOutput({tag, "_done_seen"}, got, 1'b1);
    checkOutput({tag, "_latency"}, cyc, exp_lat);
    checkOutput({tag, "_err"}, err, exp_err);
    checkOutput({tag, "_y"}, y, exp_y);
    setMacIdle();
    start = 1'b0; cfg_we = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput({tag, "_done_one_cycle"}, done, 1'b0);
    checkOutput({tag, "_y_held"}, y, exp_y);
    checkOutput({tag, "_err_held"}, err, exp_err);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_done"}, done, 1'b0);
    checkOutput({tag, "_err"}, err, 1'b0);
    checkOutput({tag, "_y"}, y, '0);
    checkOutput({tag, "_wr_en"}, {mac_bus.mac_wr_en_sig_o, mac_bus.mac_wr_en_coeff_o}, '0);
    checkOutput({tag, "_last"}, {mac_bus.mac_last_sig_o, mac_bus.mac_last_coeff_o}, '0);
    checkOutput({tag, "_coeff"}, mac_bus.mac_coeff_o, '0);
    checkOutput({tag, "_signal"}, mac_bus.mac_signal_o, '0);
    checkOutput({tag, "_len"}, mac_bus.mac_taylor_len_o, '0);
  endtask

  initial begin
    int d0;
    n_checks = 0; n_errors = 0; done_cnt = 0; chk_en = 0;
    start = 0; x = '0; len = '0; cfg_we = 0; cfg_addr = '0; cfg_data = '0;
    setMacIdle();
    mac_bus.mac_result_i = '0;
    for (int k = 0; k < 32; k++) model_table[k] = '0;

    #2 rstn = 1'b0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    @(posedge clk); #1 rstn = 1'b1;

    $display("[TB] loading tanh coefficient table");
    for (int k = 0; k < 32; k++) cfgWrite(k, toF32(tanhCoef(k)));
    chk_en = 1;

    $display("[TB] test 1: N=30 tanh, mac always ready");
    applyStimulus("t1", 30, 32'h3E308D3D, 32'h3E2F5C29, 0, 0, 0, 0, 0, 0,
                  37, 1'b0, 32'h3E2F5C29);
    checkOutput("t1_coeff_beats", coeff_beats, 31);
    checkOutput("t1_sig_beats", sig_beats, 30);
    checkOutput("t1_c1_beat", c1_seen, 32'h3F800000);

    $display("[TB] test 2: N=0");
    cfgWrite(0, 32'h3F800000);
    applyStimulus("t2", 0, 32'h40000000, 32'h3F800000, 0, 0, 0, 0, 0, 0,
                  7, 1'b0, 32'h3F800000);
    checkOutput("t2_coeff_beats", coeff_beats, 1);
    checkOutput("t2_sig_beats", sig_beats, 0);

    $display("[TB] test 3: 5-cycle multiplier-full stall");
    applyStimulus("t3", 8, 32'h3F000000, 32'h3E800000, 3, 5, 0, 0, 0, 0,
                  20, 1'b0, 32'h3E800000);
    checkOutput("t3_coeff_beats", coeff_beats, 9);
    checkOutput("t3_sig_beats", sig_beats, 8);

    $display("[TB] test 4: drain timeout");
    applyStimulus("t4", 2, 32'h3F000000, 32'h12345678, 0, 0, 0, 0, 1, 0,
                  2 + 3 + TIMEOUT, 1'b1, 32'h3E800000);

    $display("[TB] test 5: cfg write and start while busy");
    applyStimulus("t5", 6, 32'h3F400000, 32'h3F111111, 0, 0, 0, 0, 0, 1,
                  13, 1'b0, 32'h3F111111);
    d0 = done_cnt;
    repeat (12) @(negedge clk);
    checkOutput("t5_single_done", done_cnt, d0);
    checkOutput("t5_idle_after", busy, 1'b0);

    $display("[TB] test 7: sample-ready gap and drain glitch");
    applyStimulus("t7", 3, 32'h3DCCCCCD, 32'h3DCC0000, 0, 0, 2, 9, 0, 0,
                  14, 1'b0, 32'h3DCC0000);

    $display("[TB] test 6: reset during ISSUE");
    chk_en = 0;
    @(posedge clk); #1;
    start = 1'b1; x = 32'h3F000000; len = 5'd10;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    d0 = done_cnt;
    rstn = 1'b0;
    #1;
    checkAllZero("t6_async");
    @(posedge clk);
    @(posedge clk); #1 rstn = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("t6_no_done", done_cnt, d0);
    chk_en = 1;
    applyStimulus("t6_rerun", 30, 32'h3E308D3D, 32'h3E2F5C29, 0, 0, 0, 0, 0, 0,
                  37, 1'b0, 32'h3E2F5C29);
    checkOutput("t6_c1_beat", c1_seen, 32'h3F800000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
